// File: rtl/class_sched_arbiter_pkg.sv
// class_sched_arbiter_pkg: shared router definitions (word layout, default width, scheduler states)
package class_sched_arbiter_pkg;
   localparam int DEF_WORD_SIZE = 12;
   localparam int CLASS_MSB     = DEF_WORD_SIZE - 1;
   localparam int CLASS_LSB     = DEF_WORD_SIZE - 2;
   localparam int DEST_MSB      = DEF_WORD_SIZE - 3;
   localparam int DEST_LSB      = DEF_WORD_SIZE - 4;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_XFER = 2'd2
   } state_t;
endpackage

// File: rtl/class_sched_arbiter_grant_sel.sv
// class_grant_sel: combinational rotating-priority pick among four class requests
//   req       in  4  request per class FIFO (non-empty)
//   start     in  2  index searched first; search wraps 3->0
//   gnt       out 2  granted index
//   gnt_valid out 1  any request present
module class_grant_sel (
   input  logic [3:0] req,
   input  logic [1:0] start,
   output logic [1:0] gnt,
   output logic       gnt_valid
);
   // Walk from the farthest offset down so the nearest request to start wins last.
   always_comb begin
      gnt       = start;
      gnt_valid = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (req[start + 2'(k)]) begin
            gnt       = start + 2'(k);
            gnt_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/class_sched_arbiter.sv
// class_sched_arbiter: moves one word at a time from four class FIFOs to the destination FIFO in word[9:8]
//   clk              in  1            rising-edge clock
//   reset            in  1            synchronous, active-low
//   fifo_empty       in  4            class FIFO empty flags
//   data_in          in  4*WORD_SIZE  class FIFO read data, FIFO i at [i*WORD_SIZE +: WORD_SIZE]
//   dest_almost_full in  4            destination FIFO almost-full flags
//   pop              out 4            one-hot class FIFO pop pulse
//   push             out 4            one-hot destination FIFO push pulse
//   data_out         out WORD_SIZE    word presented with push
//   word_count       out COUNT_W      words pushed since reset, wrapping
//   busy             out 1            transfer in progress
// Build option: ROUND_ROBIN_EN selects rotating priority; otherwise class 0 always wins.
module class_sched_arbiter
   import class_sched_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int COUNT_W   = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             fifo_empty,
   input  logic [4*WORD_SIZE-1:0] data_in,
   input  logic [3:0]             dest_almost_full,
   output logic [3:0]             pop,
   output logic [3:0]             push,
   output logic [WORD_SIZE-1:0]   data_out,
   output logic [COUNT_W-1:0]     word_count,
   output logic                   busy
);
   state_t               state, state_n;
   logic [1:0]           sel, sel_n, gnt, start;
   logic                 gnt_valid;
   logic [3:0]           pop_n, push_n;
   logic [WORD_SIZE-1:0] data_n, word;
   logic [COUNT_W-1:0]   count_n;
`ifdef ROUND_ROBIN_EN
   logic [1:0]           rr_ptr, rr_n;
   assign start = rr_ptr;
`else
   assign start = 2'd0;
`endif

   class_grant_sel u_grant (
      .req       (~fifo_empty),
      .start     (start),
      .gnt       (gnt),
      .gnt_valid (gnt_valid)
   );

   assign word = data_in[32'(sel)*WORD_SIZE +: WORD_SIZE];
   assign busy = state != ST_IDLE;

   always_comb begin
      state_n = state;
      sel_n   = sel;
      pop_n   = 4'b0000;
      push_n  = 4'b0000;
      data_n  = data_out;
      count_n = word_count;
`ifdef ROUND_ROBIN_EN
      rr_n    = rr_ptr;
`endif
      case (state)
         ST_IDLE: if (!(|dest_almost_full) && gnt_valid) begin
            pop_n   = 4'b0001 << gnt;
            sel_n   = gnt;
            state_n = ST_READ;
`ifdef ROUND_ROBIN_EN
            rr_n    = gnt + 2'd1;
`endif
         end
         // The FIFO presents the popped word during this cycle's successor.
         ST_READ: state_n = ST_XFER;
         ST_XFER: begin
            data_n  = word;
            push_n  = 4'b0001 << word[WORD_SIZE-3:WORD_SIZE-4];
            count_n = word_count + 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         sel        <= 2'd0;
         pop        <= 4'b0000;
         push       <= 4'b0000;
         data_out   <= '0;
         word_count <= '0;
`ifdef ROUND_ROBIN_EN
         rr_ptr     <= 2'd0;
`endif
      end else begin
         state      <= state_n;
         sel        <= sel_n;
         pop        <= pop_n;
         push       <= push_n;
         data_out   <= data_n;
         word_count <= count_n;
`ifdef ROUND_ROBIN_EN
         rr_ptr     <= rr_n;
`endif
      end
   end
endmodule

// File: tb/tb_class_sched_arbiter.sv
// tb_class_sched_arbiter: randomized check of class_sched_arbiter against queue-based FIFO and grant model
module tb_class_sched_arbiter;
   localparam int W  = 12;
   localparam int CW = 5;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    fifo_empty = 4'hF;
   logic [3:0]    dest_almost_full = 4'h0;
   logic [4*W-1:0] data_in = '0;
   logic [3:0]    pop, push;
   logic [W-1:0]  data_out;
   logic [CW-1:0] word_count;
   logic          busy;
   logic [W-1:0]  q[4][$];
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  rd[4];
   int            rr = 0, cnt = 0, since_pop = 0, last_g = 0;
   bit            stall = 0, chain = 0;
   int            n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   class_sched_arbiter #(.WORD_SIZE(W), .COUNT_W(CW)) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo_empty       (fifo_empty),
      .data_in          (data_in),
      .dest_almost_full (dest_almost_full),
      .pop              (pop),
      .push             (push),
      .data_out         (data_out),
      .word_count       (word_count),
      .busy             (busy)
   );

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected grant: first non-empty queue scanning from the priority start.
   function automatic int pick();
      int s = 0;
`ifdef ROUND_ROBIN_EN
      s = rr;
`endif
      for (int k = 0; k < 4; k++)
         if (q[(s + k) % 4].size() != 0) return (s + k) % 4;
      return -1;
   endfunction

   function automatic int pending();
      return q[0].size() + q[1].size() + q[2].size() + q[3].size() + exp_q.size();
   endfunction

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i] = q[i].size() == 0;
         if (i != last_g) rd[i] = W'($urandom);
      end
      data_in = {rd[3], rd[2], rd[1], rd[0]};
   endtask

   task automatic tick();
      int g;
      logic [W-1:0] w;
      @(negedge clk);
      since_pop++;
      if (reset) begin
         if (stall) chk("stall_pop", pop, 0);
         if (pop != 0) begin
            g = pick();
            if (g < 0) chk("pop_spurious", pop, 0);
            else begin
               chk("pop_grant", pop, 1 << g);
               chk("busy_pop", busy, 1);
               if (chain) chk("pop_gap", since_pop, 3);
               chain = 1;
               since_pop = 0;
               w = q[g].pop_front();
               rd[g] = w;
               last_g = g;
               exp_q.push_back(w);
               rr = (g + 1) % 4;
            end
         end
         if (push != 0) begin
            if (exp_q.size() == 0) chk("push_spurious", push, 0);
            else begin
               w = exp_q.pop_front();
               cnt = (cnt + 1) % (1 << CW);
               chk("push_dest", push, 1 << w[9:8]);
               chk("data_out", data_out, w);
               chk("word_count", word_count, cnt);
               chk("push_latency", since_pop, 2);
               chk("busy_push", busy, 0);
            end
         end
      end
      drive();
   endtask

   task automatic drain(int maxc);
      int n = 0;
      chain = 0;
      while ((pending() != 0 || busy) && n < maxc) begin
         tick();
         n++;
      end
      if (n >= maxc) chk("drain_timeout", pending(), 0);
      chain = 0;
   endtask

   task automatic load(int i, logic [W-1:0] w);
      q[i].push_back(w);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4; i++) begin
         rd[i] = '0;
         load(i, W'($urandom));
      end
      drive();
      repeat (3) tick();
      chk("rst_pop", pop, 0);
      chk("rst_push", push, 0);
      chk("rst_data", data_out, 0);
      chk("rst_count", word_count, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < 4; i++) q[i].delete();
      drive();
      reset = 1'b1;

      load(2, 12'hA5C);
      drive();
      drain(20);
      chk("single_data", data_out, 12'hA5C);
      chk("single_count", word_count, 1);

      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) load(i, W'($urandom));
      drive();
      drain(200);

      load(1, W'($urandom));
      dest_almost_full = 4'b0001;
      stall = 1;
      drive();
      repeat (6) tick();
      stall = 0;
      dest_almost_full = 4'b0000;
      tick();
      chk("stall_release", pop, 4'b0010);
      drain(20);

      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 4; i++)
            repeat ($urandom_range(0, 5)) load(i, W'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            dest_almost_full = 4'($urandom_range(1, 15));
            stall = 1;
            drive();
            repeat (3) tick();
            stall = 0;
            dest_almost_full = 4'b0000;
         end
         drive();
         drain(300);
      end

      load(0, W'($urandom));
      drive();
      n = 0;
      do tick(); while (pop == 0 && ++n < 10);
      chk("midop_pop", pop, 4'b0001);
      tick();
      reset = 1'b0;
      tick();
      chk("midop_push", push, 0);
      chk("midop_count", word_count, 0);
      chk("midop_busy", busy, 0);
      exp_q.delete();
      cnt = 0;
      rr = 0;
      chain = 0;
      reset = 1'b1;
      tick();

      for (int j = 0; j < 32; j++) load($urandom_range(0, 3), W'($urandom));
      drive();
      drain(300);
      chk("wrap_count", word_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
